// File: rtl/simd_pkg.sv
// Shared lane-mode encodings, saturation limits and lane-sign helper for the packed-SIMD datapath.
// Width mode 3 is an alias of the 32-bit mode and is folded to W32 by norm_mode().
package simd_pkg;

    localparam int LANES_MAX = 4;

    localparam logic [1:0] W8  = 2'd0;
    localparam logic [1:0] W16 = 2'd1;
    localparam logic [1:0] W32 = 2'd2;

    localparam logic [7:0]  SAT8_MAX  = 8'h7F;
    localparam logic [7:0]  SAT8_MIN  = 8'h80;
    localparam logic [15:0] SAT16_MAX = 16'h7FFF;
    localparam logic [15:0] SAT16_MIN = 16'h8000;
    localparam logic [31:0] SAT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT32_MIN = 32'h8000_0000;

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? W32 : m;
    endfunction

    // Sign bit of each lane, packed at the lane index; unused lane slots read 0.
    function automatic logic [3:0] lane_signs(input logic [31:0] v, input logic [1:0] m);
        case (m)
            W8:      return {v[31], v[23], v[15], v[7]};
            W16:     return {2'b00, v[31], v[15]};
            default: return {3'b000, v[31]};
        endcase
    endfunction

endpackage

// File: rtl/simd_lane_sat.sv
// One signed lane: flags overflow of a - b from the operand/result signs and optionally clamps.
// Purely combinational; the clamp direction follows the sign of the minuend.
module simd_lane_sat #(
    parameter int           W       = 8,
    parameter logic [W-1:0] SAT_MAX = '0,
    parameter logic [W-1:0] SAT_MIN = '0
) (
    input  logic [W-1:0] raw_i,
    input  logic         sign_a_i,
    input  logic         sign_b_i,
    input  logic         sign_r_i,
    input  logic         saturate_i,
    output logic [W-1:0] res_o,
    output logic         ovf_o
);

    assign ovf_o = (sign_a_i != sign_b_i) && (sign_r_i != sign_a_i);
    assign res_o = (saturate_i && ovf_o) ? (sign_a_i ? SAT_MIN : SAT_MAX) : raw_i;

endmodule

// File: rtl/simd_sub_pipe.sv
// Two-stage packed-SIMD signed subtractor (4x8 / 2x16 / 1x32) with per-beat wrap or saturate.
// Optional sticky overflow flag enabled by defining SIMD_SUB_STICKY_OVF_EN.
module simd_sub_pipe #(
    parameter int DATA_W    = 32,
    parameter int LANES_MAX = simd_pkg::LANES_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    a,
    input  logic [DATA_W-1:0]    b,
    input  logic [1:0]           width,
    input  logic                 saturate,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    c,
    output logic [LANES_MAX-1:0] ovf,
    output logic                 sticky_ovf,
    input  logic                 sticky_clr
);
    import simd_pkg::*;

    logic                 s1_valid_q;
    logic [1:0]           s1_mode_q,  s1_mode_d;
    logic                 s1_sat_q;
    logic [DATA_W-1:0]    s1_raw_q,   s1_raw_d;
    logic [3:0]           s1_sa_q,    s1_sb_q,  s1_sr_q;
    logic                 out_valid_q;
    logic [DATA_W-1:0]    c_q,        c_d;
    logic [LANES_MAX-1:0] ovf_q,      ovf_d;
    logic                 s2_load,    s1_load;
    logic [3:0]           slice_start;
    logic                 borrow_n;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    assign s1_mode_d = norm_mode(width);

    // Each 8-bit slice starting a lane gets a fresh carry-in of 1 (a + ~b + 1).
    always_comb begin
        case (s1_mode_d)
            W8:      slice_start = 4'b1111;
            W16:     slice_start = 4'b0101;
            default: slice_start = 4'b0001;
        endcase
        s1_raw_d = '0;
        borrow_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            {borrow_n, s1_raw_d[8*k +: 8]} = {1'b0, a[8*k +: 8]} + {1'b0, ~b[8*k +: 8]}
                                            + {8'd0, slice_start[k] ? 1'b1 : borrow_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= W8;
            s1_sat_q   <= 1'b0;
            s1_raw_q   <= '0;
            s1_sa_q    <= '0;
            s1_sb_q    <= '0;
            s1_sr_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mode_q <= s1_mode_d;
                s1_sat_q  <= saturate;
                s1_raw_q  <= s1_raw_d;
                s1_sa_q   <= lane_signs(a, s1_mode_d);
                s1_sb_q   <= lane_signs(b, s1_mode_d);
                s1_sr_q   <= lane_signs(s1_raw_d, s1_mode_d);
            end
        end
    end

    logic [31:0] res8, res16, res32;
    logic [3:0]  ovf8;
    logic [1:0]  ovf16;
    logic        ovf32;

    for (genvar i = 0; i < 4; i++) begin : g_l8
        simd_lane_sat #(.W(8), .SAT_MAX(SAT8_MAX), .SAT_MIN(SAT8_MIN)) u_lane (
            .raw_i(s1_raw_q[8*i +: 8]), .sign_a_i(s1_sa_q[i]), .sign_b_i(s1_sb_q[i]),
            .sign_r_i(s1_sr_q[i]), .saturate_i(s1_sat_q),
            .res_o(res8[8*i +: 8]), .ovf_o(ovf8[i]));
    end

    for (genvar i = 0; i < 2; i++) begin : g_l16
        simd_lane_sat #(.W(16), .SAT_MAX(SAT16_MAX), .SAT_MIN(SAT16_MIN)) u_lane (
            .raw_i(s1_raw_q[16*i +: 16]), .sign_a_i(s1_sa_q[i]), .sign_b_i(s1_sb_q[i]),
            .sign_r_i(s1_sr_q[i]), .saturate_i(s1_sat_q),
            .res_o(res16[16*i +: 16]), .ovf_o(ovf16[i]));
    end

    simd_lane_sat #(.W(32), .SAT_MAX(SAT32_MAX), .SAT_MIN(SAT32_MIN)) u_l32 (
        .raw_i(s1_raw_q), .sign_a_i(s1_sa_q[0]), .sign_b_i(s1_sb_q[0]),
        .sign_r_i(s1_sr_q[0]), .saturate_i(s1_sat_q),
        .res_o(res32), .ovf_o(ovf32));

    always_comb begin
        case (s1_mode_q)
            W8:      begin c_d = res8;  ovf_d = ovf8;            end
            W16:     begin c_d = res16; ovf_d = {2'b00, ovf16};  end
            default: begin c_d = res32; ovf_d = {3'b000, ovf32}; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                c_q   <= c_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

`ifdef SIMD_SUB_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // A set on the same edge as a clear wins.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr)
            sticky_d = 1'b0;
        if (out_valid_q && out_ready && (|ovf_q))
            sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sticky_q <= 1'b0;
        else
            sticky_q <= sticky_d;
    end

    assign sticky_ovf = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_simd_sub_pipe.sv
// Bench for simd_sub_pipe: directed corner beats, back-pressure, reset mid-flight and a random soak
// checked against an integer-arithmetic model through a scoreboard queue.
module tb_simd_sub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  width = '0;
    logic        saturate = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;
    logic [3:0]  ovf;
    logic        sticky_ovf;
    logic        sticky_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    simd_sub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .width(width), .saturate(saturate),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf),
        .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] c;
        logic [3:0]  ovf;
    } exp_t;

    // Lane-by-lane signed integer subtraction, then range check and clamp.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [1:0] w, input logic s);
        exp_t   r;
        int     lw;
        longint m, xa, yb, d, hi, lo;
        r  = '0;
        lw = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
        m  = (longint'(1) << lw) - 1;
        hi = (longint'(1) << (lw - 1)) - 1;
        lo = -(longint'(1) << (lw - 1));
        for (int i = 0; i < 32 / lw; i++) begin
            xa = longint'(x >> (i * lw)) & m;
            yb = longint'(y >> (i * lw)) & m;
            if (xa > hi) xa = xa - (m + 1);
            if (yb > hi) yb = yb - (m + 1);
            d = xa - yb;
            r.ovf[i] = (d > hi) || (d < lo);
            if (s && r.ovf[i]) d = (d > hi) ? hi : lo;
            r.c = r.c | (32'(d & m) << (i * lw));
        end
        return r;
    endfunction

    exp_t        sb_q[$];
    logic        held = 1'b0;
    logic [31:0] held_c;
    logic [3:0]  held_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_c", c, held_c);
                chk("hold_ovf", 32'(ovf), 32'(held_ovf));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_c", c, e.c);
                    chk("sb_ovf", 32'(ovf), 32'(e.ovf));
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(a, b, width, saturate));
            held     = out_valid && !out_ready;
            held_c   = c;
            held_ovf = ovf;
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] tw, input logic ts);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1; a = ta; b = tb_; width = tw; saturate = ts;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] ec, input logic [3:0] eo);
        int n;
        n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_c"}, c, ec);
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
    endtask

    logic [31:0] bpa [4];
    logic [31:0] bpb [4];
    logic [1:0]  bpw [4];

    initial begin
        int   idx;
        int   n;
        logic accepted;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", c, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: accepted at edge E1, out_valid only after E2.
        out_ready = 1'b1;
        send(32'h8000_0000, 32'h0000_0001, 2'd2, 1'b0);
        chk("lat_e1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_e2", 32'(out_valid), 32'd1);
        expect_out("w32_wrap", 32'h7FFF_FFFF, 4'b0001);

        send(32'h8000_0000, 32'h0000_0001, 2'd2, 1'b1);
        expect_out("w32_sat_neg", 32'h8000_0000, 4'b0001);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'd3, 1'b1);
        expect_out("w32_sat_pos", 32'h7FFF_FFFF, 4'b0001);
        send(32'h4000_0000, 32'h0000_0001, 2'd1, 1'b0);
        expect_out("w16_noborrow", 32'h4000_FFFF, 4'b0000);
        send(32'h4000_0080, 32'h0000_0001, 2'd0, 1'b1);
        expect_out("w8_sat", 32'h4000_0080, 4'b0001);
        send(32'h4000_0080, 32'h0000_0001, 2'd0, 1'b0);
        expect_out("w8_wrap", 32'h4000_007F, 4'b0001);
        send(32'h0000_0000, 32'h0000_0080, 2'd0, 1'b0);
        expect_out("w8_0m80", 32'h0000_0080, 4'b0001);
        for (int w = 0; w < 4; w++) begin
            logic [31:0] r;
            r = $urandom;
            send(r, r, 2'(w), 1'(w & 1));
            expect_out("a_eq_b", 32'd0, 4'b0000);
        end

`ifdef SIMD_SUB_STICKY_OVF_EN
        chk("sticky_pre", 32'(sticky_ovf), 32'd1);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk("sticky_clr", 32'(sticky_ovf), 32'd0);
        send(32'h0000_0080, 32'h0000_0001, 2'd0, 1'b0);
        expect_out("sticky_beat", 32'h0000_007F, 4'b0001);
        chk("sticky_set", 32'(sticky_ovf), 32'd1);
`else
        chk("sticky_tied", 32'(sticky_ovf), 32'd0);
`endif

        // Back-pressure: four beats offered against a stalled output.
        for (int i = 0; i < 4; i++) begin
            bpa[i] = $urandom; bpb[i] = $urandom; bpw[i] = 2'(i);
        end
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = 1'b1; a = bpa[idx]; b = bpb[idx]; width = bpw[idx]; saturate = 1'b1;
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rise_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        if (in_ready) idx++;
        n = 0;
        while (idx < 4 && n < 50) begin
            a = bpa[idx]; b = bpb[idx]; width = bpw[idx];
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 32'(idx), 32'd4);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drained", 32'(sb_q.size()), 32'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(32'h8000_0000, 32'h0000_0001, 2'd2, 1'b0);
        send(32'h1234_5678, 32'h0000_0001, 2'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_c", c, 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd1);
        chk("mid_rst_sticky", 32'(sticky_ovf), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Random soak with random valid/ready.
        accepted = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || accepted) begin
                if ($urandom_range(3) != 0) begin
                    in_valid = 1'b1;
                    a = $urandom;
                    b = ($urandom_range(7) == 0) ? a : $urandom;
                    if ($urandom_range(5) == 0) a = 32'h8080_8080;
                    if ($urandom_range(5) == 0) b = 32'h7F7F_7F7F;
                    width = 2'($urandom_range(3));
                    saturate = 1'($urandom_range(1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("final_empty", 32'(sb_q.size()), 32'd0);
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simd_sub_pipe.md
Name: simd_sub_pipe

Overview:
- Pipelined packed-SIMD signed subtractor, c = a - b, with per-lane wrap or saturate selected per transaction.
- It is the inverse operation of the combinational SIMD saturating adder.
- Two register stages with valid/ready handshakes on both sides, so it can sit between an operand buffer and the writeback path.
- Reports per-lane signed overflow alongside each result.

Parameters:
- DATA_W, 32, packed operand width. Only 32 is supported; it is fixed by the lane modes.
- LANES_MAX, 4, number of 8-bit lanes in width mode 0; sizes the ovf output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  32  minuend, packed lanes
- b  input  32  subtrahend, packed lanes
- width  input  2  lane mode: 0 = 4x8, 1 = 2x16, 2 = 1x32, 3 = treated as 2
- saturate  input  1  1 = signed saturate, 0 = wrap
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- c  output  32  packed difference
- ovf  output  4  per-lane signed overflow for the presented result
- sticky_ovf  output  1  accumulated overflow (only with the optional feature)
- sticky_clr  input  1  clears sticky_ovf (only with the optional feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, c=0, ovf=0, sticky_ovf=0.
  - Both stage-valid bits cleared; any in-flight beats are dropped.
  - in_ready=1 in the cycle after reset.
- Handshake:
  - A beat transfers when valid && ready on that side.
  - Once out_valid=1, c and ovf are held stable until out_ready=1.
- Stage 2 (output register) loads when !out_valid || out_ready.
- Stage 1 loads when !s1_valid || (stage 2 loads).
- in_ready = !s1_valid || (stage 2 loads). A combinational path from out_ready to in_ready is permitted.
- Latency: exactly 2 cycles from input acceptance to out_valid when unstalled. Sustained throughput is 1 beat/cycle.
- Stage 1 work:
  - Registers width and saturate.
  - Computes the raw difference per 8-bit slice, with borrow chained across slice boundaries according to width.
  - Captures per-lane sign of a, sign of b, and sign of the raw result.
- Stage 2 work:
  - Overflow for a lane is sign(a) != sign(b) && sign(raw) != sign(a).
  - saturate=0: lane result = raw (wrapped); ovf still reported.
  - saturate=1 and overflow: lane = most-positive (0x7F / 0x7FFF / 0x7FFFFFFF) if sign(a)=0, else most-negative (0x80 / 0x8000 / 0x80000000).
- ovf mapping:
  - width 0: ovf[i] = byte lane i.
  - width 1: ovf[1:0] = half-lanes; ovf[3:2] = 0.
  - width 2 or 3: ovf[0] only; ovf[3:1] = 0.
- Mixed modes are allowed on back-to-back beats; each beat carries its own width and saturate through the pipe.
- Boundaries:
  - Full pipe with out_ready=0: in_ready=0 and the input is not sampled.
  - out_ready rising while full: one beat is accepted in that same cycle.
  - a = b gives 0 with no overflow in every mode.
  - 0x80 - 0x01 overflows; 0x00 - 0x80 overflows (result sign is wrong).
  - rst has priority over every handshake.

Optional Feature:
- Macro SIMD_SUB_STICKY_OVF_EN.
- Defined:
  - sticky_ovf is set at any output transfer (out_valid && out_ready) with |ovf = 1.
  - Cleared by sticky_clr=1 at a clk edge; if clear and set coincide, set wins.
  - Reset clears it.
- Undefined: sticky_ovf is tied to 0 and sticky_clr is ignored.

Decomposition:
- Shared package simd_pkg holds:
  - lane-mode encodings W8=2'd0, W16=2'd1, W32=2'd2;
  - per-mode saturation constants (max/min for 8, 16 and 32 bits);
  - LANES_MAX.
- One sub-module, simd_lane_sat: combinational per-lane overflow detect and clamp, instantiated in stage 2 for each mode.

Test Plan:
- width=2, saturate=0, a=0x80000000, b=0x00000001 -> c=0x7FFFFFFF, ovf=4'b0001, out_valid exactly 2 cycles after acceptance.
- width=2, saturate=1, same operands -> c=0x80000000, ovf=4'b0001; a=0x7FFFFFFF, b=0xFFFFFFFF -> c=0x7FFFFFFF.
- width=1, saturate=0, a=0x4000_0000, b=0x0000_0001 -> c=0x4000_FFFF, ovf=0 (no borrow crosses into the upper half).
- width=0, saturate=1, a=0x40_00_00_80, b=0x00_00_00_01 -> c=0x40_00_00_80, ovf=4'b0001; with saturate=0 -> c=0x40_00_00_7F.
- Back-pressure: send 4 beats with out_ready=0 -> in_ready drops after 2 accepted. Then raise out_ready -> all 4 results arrive in order, unchanged while stalled.
- Reset mid-flight with 2 beats in the pipe -> out_valid=0 the next cycle and no stale result appears. With SIMD_SUB_STICKY_OVF_EN defined, check that sticky_ovf sets on an overflowing beat and clears on sticky_clr.
